tx_control2: RTL and testbench
==============================

TX_CONTROL2 -- requirements
Module: tx_control2

Interface
REQ-001 SHALL have parameter FIFOSIZE, default 10: log2 depth of the internal sample FIFO.
REQ-002 SHALL have parameter SR_ADDR, default 8'd128: settings-bus address of the control register.
REQ-003 SHALL have ports: clk in 1, single clock; rst in 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports: set_stb in 1; set_addr in 8; set_data in 32; settings write strobe, address and data.
REQ-005 SHALL have port master_time in 32: free-running timebase.
REQ-006 SHALL have ports: rd_dat_i in 32; rd_flags_i in 4 ([1]=eop); rd_ready_i in 1; rd_ready_o out 1: buffer-pool read interface.
REQ-007 SHALL have ports: sample out 32; run out 1; strobe in 1: DSP core interface.
REQ-008 SHALL have ports: underrun out 1, sticky; late out 1, sticky; pkt_count out 16; fifo_occupied out 16; fifo_full out 1; fifo_empty out 1; debug out 32.

Function
REQ-009 Packet format SHALL be: word0 [31:16]=16'hdead, [2:0]={eob,imm,rsvd}; word1 [31:16]=16'hcafe; word2 = send time; then payload until eop.
REQ-010 Ingress FSM SHALL have states IDLE, CTRL, TIME, PKT; it advances only on rd_ready_i & rd_ready_o.
REQ-011 IDLE->CTRL on 16'hdead, latching flags; CTRL->TIME on 16'hcafe, otherwise ->IDLE; TIME->PKT always; PKT->IDLE on eop.
REQ-012 IDLE with eop, or TIME with eop, SHALL return to IDLE and write nothing.
REQ-013 FIFO entry SHALL be 36 bits {tag, imm, eob, eop, data}; TIME writes tag=1 with the send time; PKT writes tag=0 payload.
REQ-014 rd_ready_o SHALL be rd_ready_i & fifo has space & ~clear & enable.
REQ-015 Egress FSM SHALL have states IDLE, WAIT_TIME, RUNNING, CONT, UNDERRUN, LATE.
REQ-016 IDLE, head tag=1: pop, latch time and flags; imm -> RUNNING; otherwise compute d = master_time - time as signed 32-bit; d>0 -> LATE, else WAIT_TIME.
REQ-017 IDLE, head tag=0: pop and discard one entry per cycle (resync).
REQ-018 WAIT_TIME -> RUNNING in the cycle after master_time == latched time.
REQ-019 RUNNING, strobe: if empty -> UNDERRUN; else pop, sample = popped data; on eop increment pkt_count (wraps at 16'hffff), then eob -> IDLE else -> CONT.
REQ-020 CONT, strobe: head tag=1 -> pop it, ignoring its time, -> RUNNING; empty -> UNDERRUN.
REQ-021 UNDERRUN SHALL assert clear for exactly one cycle, flushing the FIFO and forcing ingress to IDLE; set underrun; then -> IDLE.
REQ-022 LATE SHALL pop one entry per cycle until an eop entry is popped, set late, then -> IDLE.
REQ-023 run SHALL be high only in RUNNING and CONT.
REQ-024 A settings write with set_addr==SR_ADDR SHALL load enable=set_data[0]; set_data[1]=1 SHALL clear underrun, late and pkt_count.
REQ-025 Simultaneous sticky set and settings clear: set SHALL win.
REQ-026 debug SHALL be {16'b0, underrun, late, ingress state[1:0], egress state[2:0], fifo_full, fifo_empty, clear, enable, 5'b0}.

Reset
REQ-027 On rst low: both FSMs IDLE; enable=0, clear=0, underrun=0, late=0, pkt_count=0, sample=0, run=0; FIFO empty.
REQ-028 rst asserted mid-packet SHALL abort immediately; no partial packet survives reset.

Configuration
REQ-029 Macro TX_CONTROL2_TIMED_EN: defined -> REQ-016/018/022 timing as specified; undefined -> every packet behaves as imm=1, late stays 0, LATE and WAIT_TIME are unreachable, the time word is still consumed.

Structure
REQ-030 Package tx_control2_pkg SHALL hold the ingress/egress state encodings, the 16'hdead/16'hcafe magic constants and the entry field positions.
REQ-031 The FIFO SHALL be one fifo_cascade instance, WIDTH 36, SIZE FIFOSIZE.

Verification
REQ-032 enable=1, imm packet of 4 words, strobe every cycle -> 4 samples in order, run high for 4 strobes, pkt_count=1.
REQ-033 Timed packet with time=master_time+100 -> run rises 101 cycles after the header is popped (TIMED_EN defined).
REQ-034 Timed packet with time=master_time-5 -> late=1, no run, FIFO drained through eop.
REQ-035 eob=0 packet, no follow-on, strobe continues -> underrun=1, single-cycle clear, FIFO empty.
REQ-036 Bad word1 (16'hbeef) -> no FIFO writes, ingress back at IDLE; next valid packet plays normally.
REQ-037 rst low during RUNNING with 10 words queued -> all outputs at reset values, fifo_empty=1.

Source files
------------

// File: rtl/tx_control2_pkg.sv
// Shared definitions for the tx_control2 transmit controller: ingress and
// egress state encodings, packet magic words and the layout of a FIFO entry.
// Optional feature macro: TX_CONTROL2_TIMED_EN (timed transmission).
package tx_control2_pkg;

   typedef enum logic [1:0] {
      IN_IDLE = 2'd0,
      IN_CTRL = 2'd1,
      IN_TIME = 2'd2,
      IN_PKT  = 2'd3
   } ingress_t;

   typedef enum logic [2:0] {
      EG_IDLE      = 3'd0,
      EG_WAIT_TIME = 3'd1,
      EG_RUNNING   = 3'd2,
      EG_CONT      = 3'd3,
      EG_UNDERRUN  = 3'd4,
      EG_LATE      = 3'd5
   } egress_t;

   localparam logic [15:0] MAGIC_CTRL = 16'hdead;
   localparam logic [15:0] MAGIC_TIME = 16'hcafe;

   localparam int ENTRY_WIDTH = 36;
   localparam int ENTRY_TAG   = 35;
   localparam int ENTRY_IMM   = 34;
   localparam int ENTRY_EOB   = 33;
   localparam int ENTRY_EOP   = 32;

   // Packs one FIFO entry: {tag, imm, eob, eop, data}.
   function automatic logic [ENTRY_WIDTH-1:0] makeEntry(input logic tag, input logic imm,
                                                         input logic eob, input logic eop,
                                                         input logic [31:0] data);
      return {tag, imm, eob, eop, data};
   endfunction

endpackage

// File: rtl/tx_control2_fifo_cascade.sv
// First-word-fall-through sample FIFO for tx_control2 (module fifo_cascade).
// Depth is 2**SIZE entries; a synchronous clear empties it in one cycle.
// Optional feature macro of the parent design: TX_CONTROL2_TIMED_EN (unused here).
module fifo_cascade #(
   parameter int WIDTH = 36,
   parameter int SIZE  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_write,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_read,
   output logic [SIZE:0]    o_occupied
);

   localparam logic [SIZE:0] DEPTH = {1'b1, {SIZE{1'b0}}};

   logic [WIDTH-1:0] r_mem [2**SIZE];
   logic [SIZE-1:0]  r_wrPtr;
   logic [SIZE-1:0]  r_rdPtr;
   logic [SIZE:0]    r_count;
   logic             w_doWrite;
   logic             w_doRead;

   assign o_full     = (r_count == DEPTH);
   assign o_valid    = (r_count != '0);
   assign o_data     = r_mem[r_rdPtr];
   assign o_occupied = r_count;
   assign w_doWrite  = i_write & ~o_full;
   assign w_doRead   = i_read & o_valid;

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_doWrite) r_mem[r_wrPtr] <= i_data;
   end

   // Pointer and occupancy bookkeeping, with clear taking priority over traffic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doWrite) r_wrPtr <= r_wrPtr + SIZE'(1);
         if (w_doRead)  r_rdPtr <= r_rdPtr + SIZE'(1);
         case ({w_doWrite, w_doRead})
            2'b10:   r_count <= r_count + (SIZE+1)'(1);
            2'b01:   r_count <= r_count - (SIZE+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tx_control2.sv
// Transmit controller: parses buffer-pool packets into a sample FIFO and
// plays them out to the DSP core on strobe, immediately or at a send time.
// Optional feature macro: TX_CONTROL2_TIMED_EN. Without it every packet is
// played as if imm were set and the late path is never taken.
module tx_control2
   import tx_control2_pkg::*;
#(
   parameter int         FIFOSIZE = 10,
   parameter logic [7:0] SR_ADDR  = 8'd128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [31:0] master_time,
   input  logic [31:0] rd_dat_i,
   input  logic [3:0]  rd_flags_i,
   input  logic        rd_ready_i,
   output logic        rd_ready_o,
   output logic [31:0] sample,
   output logic        run,
   input  logic        strobe,
   output logic        underrun,
   output logic        late,
   output logic [15:0] pkt_count,
   output logic [15:0] fifo_occupied,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic [31:0] debug
);

   ingress_t               r_inState;
   egress_t                r_egState;
   logic                   r_inImm;
   logic                   r_inEob;
   logic                   r_eob;
   logic                   r_enable;
   logic                   r_clear;
   logic                   r_underrun;
   logic                   r_late;
   logic [15:0]            r_pktCount;
   logic [31:0]            r_sample;
`ifdef TX_CONTROL2_TIMED_EN
   logic [31:0]            r_time;
   logic signed [31:0]     w_delta;
`endif
   logic                   w_eop;
   logic                   w_rdFire;
   logic                   w_wrEn;
   logic [ENTRY_WIDTH-1:0] w_wrData;
   logic [ENTRY_WIDTH-1:0] w_head;
   logic                   w_headValid;
   logic                   w_headTag;
   logic                   w_pop;
   logic                   w_full;
   logic [FIFOSIZE:0]      w_occupied;
   logic                   w_unusedBits;

   assign w_eop        = rd_flags_i[1];
   assign rd_ready_o   = rd_ready_i & ~w_full & ~r_clear & r_enable;
   assign w_rdFire     = rd_ready_i & rd_ready_o;
   assign w_headTag    = w_head[ENTRY_TAG];
   assign w_unusedBits = ^{rd_flags_i[3:2], rd_flags_i[0], w_head[ENTRY_IMM], master_time};
`ifdef TX_CONTROL2_TIMED_EN
   assign w_delta      = $signed(master_time - w_head[31:0]);
`endif

   assign sample        = r_sample;
   assign run           = (r_egState == EG_RUNNING) || (r_egState == EG_CONT);
   assign underrun      = r_underrun;
   assign late          = r_late;
   assign pkt_count     = r_pktCount;
   assign fifo_occupied = 16'(w_occupied);
   assign fifo_full     = w_full;
   assign fifo_empty    = ~w_headValid;
   assign debug         = {16'b0, r_underrun, r_late, r_inState, r_egState,
                           w_full, ~w_headValid, r_clear, r_enable, 5'b0};

   fifo_cascade #(
      .WIDTH (ENTRY_WIDTH),
      .SIZE  (FIFOSIZE)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (r_clear),
      .i_data     (w_wrData),
      .i_write    (w_wrEn),
      .o_full     (w_full),
      .o_data     (w_head),
      .o_valid    (w_headValid),
      .i_read     (w_pop),
      .o_occupied (w_occupied)
   );

   // Ingress write path: the time word becomes a tagged entry, payload words untagged ones.
   always_comb begin
      w_wrEn   = 1'b0;
      w_wrData = makeEntry(1'b0, r_inImm, r_inEob, w_eop, rd_dat_i);
      if (w_rdFire) begin
         case (r_inState)
            IN_TIME: begin
               if (!w_eop) begin
                  w_wrEn   = 1'b1;
                  w_wrData = makeEntry(1'b1, r_inImm, r_inEob, 1'b0, rd_dat_i);
               end
            end
            IN_PKT:  w_wrEn = 1'b1;
            default: w_wrEn = 1'b0;
         endcase
      end
   end

   // Ingress FSM: walks the header words and drops anything that does not parse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inState <= IN_IDLE;
         r_inImm   <= 1'b0;
         r_inEob   <= 1'b0;
      end else if (r_clear) begin
         r_inState <= IN_IDLE;
      end else if (w_rdFire) begin
         case (r_inState)
            IN_IDLE: begin
               if (!w_eop && (rd_dat_i[31:16] == MAGIC_CTRL)) begin
                  r_inState <= IN_CTRL;
                  r_inEob   <= rd_dat_i[2];
                  r_inImm   <= rd_dat_i[1];
               end
            end
            IN_CTRL: r_inState <= (!w_eop && (rd_dat_i[31:16] == MAGIC_TIME)) ? IN_TIME : IN_IDLE;
            IN_TIME: r_inState <= w_eop ? IN_IDLE : IN_PKT;
            IN_PKT:  if (w_eop) r_inState <= IN_IDLE;
            default: r_inState <= IN_IDLE;
         endcase
      end
   end

   // Egress pop decision for the current state.
   always_comb begin
      w_pop = 1'b0;
      case (r_egState)
         EG_IDLE:    w_pop = w_headValid;
         EG_RUNNING: w_pop = strobe & w_headValid;
         EG_CONT:    w_pop = strobe & w_headValid & w_headTag;
         EG_LATE:    w_pop = w_headValid;
         default:    w_pop = 1'b0;
      endcase
   end

   // Egress FSM plus control register; sticky sets come after the settings clear so they win.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_egState  <= EG_IDLE;
         r_eob      <= 1'b0;
         r_enable   <= 1'b0;
         r_clear    <= 1'b0;
         r_underrun <= 1'b0;
         r_late     <= 1'b0;
         r_pktCount <= 16'd0;
         r_sample   <= 32'd0;
`ifdef TX_CONTROL2_TIMED_EN
         r_time     <= 32'd0;
`endif
      end else begin
         r_clear <= 1'b0;
         if (set_stb && (set_addr == SR_ADDR)) begin
            r_enable <= set_data[0];
            if (set_data[1]) begin
               r_underrun <= 1'b0;
               r_late     <= 1'b0;
               r_pktCount <= 16'd0;
            end
         end
         case (r_egState)
            EG_IDLE: begin
               if (w_headValid && w_headTag) begin
                  r_eob <= w_head[ENTRY_EOB];
`ifdef TX_CONTROL2_TIMED_EN
                  r_time <= w_head[31:0];
                  if (w_head[ENTRY_IMM])       r_egState <= EG_RUNNING;
                  else if (w_delta > 32'sd0)   r_egState <= EG_LATE;
                  else                         r_egState <= EG_WAIT_TIME;
`else
                  r_egState <= EG_RUNNING;
`endif
               end
            end
            EG_WAIT_TIME: begin
`ifdef TX_CONTROL2_TIMED_EN
               if (master_time == r_time) r_egState <= EG_RUNNING;
`else
               r_egState <= EG_IDLE;
`endif
            end
            EG_RUNNING: begin
               if (strobe) begin
                  if (!w_headValid) begin
                     r_egState <= EG_UNDERRUN;
                     r_clear   <= 1'b1;
                  end else begin
                     r_sample <= w_head[31:0];
                     if (w_head[ENTRY_EOP]) begin
                        r_pktCount <= r_pktCount + 16'd1;
                        r_egState  <= r_eob ? EG_IDLE : EG_CONT;
                     end
                  end
               end
            end
            EG_CONT: begin
               if (strobe) begin
                  if (!w_headValid) begin
                     r_egState <= EG_UNDERRUN;
                     r_clear   <= 1'b1;
                  end else if (w_headTag) begin
                     r_eob     <= w_head[ENTRY_EOB];
                     r_egState <= EG_RUNNING;
                  end else begin
                     r_egState <= EG_IDLE;
                  end
               end
            end
            EG_UNDERRUN: begin
               r_underrun <= 1'b1;
               r_egState  <= EG_IDLE;
            end
            EG_LATE: begin
               if (w_headValid && w_head[ENTRY_EOP]) begin
`ifdef TX_CONTROL2_TIMED_EN
                  r_late <= 1'b1;
`endif
                  r_egState <= EG_IDLE;
               end
            end
            default: r_egState <= EG_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_control2.sv
// Directed self-checking bench for tx_control2. Timed-transmission checks
// are compiled in when TX_CONTROL2_TIMED_EN is defined; otherwise the bench
// expects untimed behaviour for packets without imm.
module tb_tx_control2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = 8'd0;
   logic [31:0] set_data = 32'd0;
   logic [31:0] master_time = 32'd1000;
   logic [31:0] rd_dat_i = 32'd0;
   logic [3:0]  rd_flags_i = 4'd0;
   logic        rd_ready_i = 1'b0;
   logic        rd_ready_o;
   logic [31:0] sample;
   logic        run;
   logic        strobe = 1'b0;
   logic        underrun;
   logic        late;
   logic [15:0] pkt_count;
   logic [15:0] fifo_occupied;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] debug;

   int checks = 0;
   int failures = 0;
   int runCycles = 0;
   int nonEmptyCycles = 0;

   tx_control2 dut (
      .clk           (clk),
      .rst           (rst),
      .set_stb       (set_stb),
      .set_addr      (set_addr),
      .set_data      (set_data),
      .master_time   (master_time),
      .rd_dat_i      (rd_dat_i),
      .rd_flags_i    (rd_flags_i),
      .rd_ready_i    (rd_ready_i),
      .rd_ready_o    (rd_ready_o),
      .sample        (sample),
      .run           (run),
      .strobe        (strobe),
      .underrun      (underrun),
      .late          (late),
      .pkt_count     (pkt_count),
      .fifo_occupied (fifo_occupied),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .debug         (debug)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Free-running timebase advancing once per clock.
   always @(posedge clk) master_time <= master_time + 32'd1;

   // Monitors counting cycles with run high and with a non-empty FIFO.
   always @(negedge clk) begin
      if (run === 1'b1)        runCycles <= runCycles + 1;
      if (fifo_empty === 1'b0) nonEmptyCycles <= nonEmptyCycles + 1;
   end

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Presents one word on the read interface and holds it until accepted.
   task automatic sendWord(input logic [31:0] d, input logic eop);
      int n;
      n = 0;
      rd_dat_i   = d;
      rd_flags_i = {2'b00, eop, 1'b0};
      rd_ready_i = 1'b1;
      #1;
      while (rd_ready_o !== 1'b1 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         checks++; failures++;
         $display("[TB] FAIL sendWord_timeout word=%h rd_ready_o=%b required=1", d, rd_ready_o);
      end
      @(negedge clk); #1;
      rd_ready_i = 1'b0;
   endtask

   // Sends a full packet: header, magic, time word, then n payload words.
   task automatic sendPacket(input logic [2:0] flags, input logic [31:0] t,
                             input int n, input logic [31:0] base);
      sendWord({16'hdead, 13'd0, flags}, 1'b0);
      sendWord({16'hcafe, 16'd0}, 1'b0);
      sendWord(t, 1'b0);
      for (int i = 0; i < n; i++) sendWord(base + 32'(i), (i == n - 1));
   endtask

   // One strobe cycle.
   task automatic pulseStrobe();
      strobe = 1'b1;
      @(negedge clk); #1;
      strobe = 1'b0;
   endtask

   // Settings-bus write to the control register.
   task automatic setCtrl(input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = 8'd128;
      set_data = d;
      @(negedge clk); #1;
      set_stb  = 1'b0;
   endtask

   // Waits, bounded, for run to go high.
   task automatic waitRun();
      int n;
      n = 0;
      while (run !== 1'b1 && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         checks++; failures++;
         $display("[TB] FAIL waitRun_timeout run=%b required=1", run);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (run !== 1'b0) begin failures++; $display("[TB] FAIL reset_run got=%b exp=0", run); end
      checks++; if (sample !== 32'd0) begin failures++; $display("[TB] FAIL reset_sample got=%h exp=0", sample); end
      checks++; if (fifo_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", fifo_empty); end
      checks++; if (pkt_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_pkt got=%0d exp=0", pkt_count); end
      checks++; if ({underrun, late} !== 2'b00) begin failures++; $display("[TB] FAIL reset_sticky got=%b exp=00", {underrun, late}); end
      checks++; if (debug !== 32'h0000_0080) begin failures++; $display("[TB] FAIL reset_debug got=%h exp=00000080", debug); end
      rst = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic test_imm();
      setCtrl(32'd1);
      sendPacket(3'b110, 32'd0, 4, 32'hA000_0000);
      waitRun();
      for (int i = 0; i < 4; i++) begin
         checks++; if (run !== 1'b1) begin failures++; $display("[TB] FAIL imm_run_%0d got=%b exp=1", i, run); end
         pulseStrobe();
         checks++;
         if (sample !== 32'hA000_0000 + 32'(i)) begin
            failures++; $display("[TB] FAIL imm_sample_%0d got=%h exp=%h", i, sample, 32'hA000_0000 + 32'(i));
         end
      end
      checks++; if (run !== 1'b0) begin failures++; $display("[TB] FAIL imm_run_end got=%b exp=0", run); end
      checks++; if (pkt_count !== 16'd1) begin failures++; $display("[TB] FAIL imm_pkt got=%0d exp=1", pkt_count); end
      checks++; if (fifo_empty !== 1'b1) begin failures++; $display("[TB] FAIL imm_empty got=%b exp=1", fifo_empty); end
   endtask

   task automatic test_late();
      int r0;
      r0 = runCycles;
      sendPacket(3'b100, master_time - 32'd5, 3, 32'hB000_0000);
`ifdef TX_CONTROL2_TIMED_EN
      repeat (5) @(negedge clk);
      #1;
      checks++; if (late !== 1'b1) begin failures++; $display("[TB] FAIL late_flag got=%b exp=1", late); end
      checks++; if (runCycles !== r0) begin failures++; $display("[TB] FAIL late_norun got=%0d exp=%0d", runCycles, r0); end
      checks++; if (fifo_empty !== 1'b1) begin failures++; $display("[TB] FAIL late_drain got=%b exp=1", fifo_empty); end
      checks++; if (debug[11:9] !== 3'd0) begin failures++; $display("[TB] FAIL late_state got=%0d exp=0", debug[11:9]); end
`else
      waitRun();
      for (int i = 0; i < 3; i++) begin
         pulseStrobe();
         checks++;
         if (sample !== 32'hB000_0000 + 32'(i)) begin
            failures++; $display("[TB] FAIL untimed_sample_%0d got=%h exp=%h", i, sample, 32'hB000_0000 + 32'(i));
         end
      end
      checks++; if (late !== 1'b0) begin failures++; $display("[TB] FAIL untimed_late got=%b exp=0", late); end
      checks++; if (pkt_count !== 16'd2) begin failures++; $display("[TB] FAIL untimed_pkt got=%0d exp=2", pkt_count); end
      checks++; if (runCycles == r0) begin failures++; $display("[TB] FAIL untimed_run got=%0d cycles exp=>0", runCycles - r0); end
`endif
   endtask

`ifdef TX_CONTROL2_TIMED_EN
   task automatic test_timed();
      logic [31:0] t;
      t = master_time + 32'd100;
      sendPacket(3'b100, t, 2, 32'hC000_0000);
      checks++; if (run !== 1'b0) begin failures++; $display("[TB] FAIL timed_early got=%b exp=0", run); end
      waitRun();
      checks++;
      if (master_time !== t + 32'd1) begin
         failures++; $display("[TB] FAIL timed_rise got=%0d exp=%0d", master_time, t + 32'd1);
      end
      for (int i = 0; i < 2; i++) begin
         pulseStrobe();
         checks++;
         if (sample !== 32'hC000_0000 + 32'(i)) begin
            failures++; $display("[TB] FAIL timed_sample_%0d got=%h exp=%h", i, sample, 32'hC000_0000 + 32'(i));
         end
      end
   endtask
`endif

   task automatic test_underrun();
      sendPacket(3'b010, 32'd0, 2, 32'hD000_0000);
      waitRun();
      for (int i = 0; i < 2; i++) begin
         pulseStrobe();
         checks++;
         if (sample !== 32'hD000_0000 + 32'(i)) begin
            failures++; $display("[TB] FAIL und_sample_%0d got=%h exp=%h", i, sample, 32'hD000_0000 + 32'(i));
         end
      end
      checks++; if ({run, debug[11:9]} !== 4'b1_011) begin failures++; $display("[TB] FAIL und_cont got=%b exp=1011", {run, debug[11:9]}); end
      pulseStrobe();
      checks++; if ({debug[6], debug[11:9]} !== 4'b1_100) begin failures++; $display("[TB] FAIL und_clear_on got=%b exp=1100", {debug[6], debug[11:9]}); end
      @(negedge clk); #1;
      checks++; if (debug[6] !== 1'b0) begin failures++; $display("[TB] FAIL und_clear_off got=%b exp=0", debug[6]); end
      checks++; if (underrun !== 1'b1) begin failures++; $display("[TB] FAIL und_flag got=%b exp=1", underrun); end
      checks++; if ({fifo_empty, debug[11:9]} !== 4'b1_000) begin failures++; $display("[TB] FAIL und_idle got=%b exp=1000", {fifo_empty, debug[11:9]}); end
      setCtrl(32'd3);
      checks++; if ({underrun, late, pkt_count} !== 18'd0) begin failures++; $display("[TB] FAIL ctrl_clear got=%b/%b/%0d exp=0/0/0", underrun, late, pkt_count); end
      checks++; if (debug[5] !== 1'b1) begin failures++; $display("[TB] FAIL ctrl_enable got=%b exp=1", debug[5]); end
   endtask

   task automatic test_bad_word1();
      int e0;
      e0 = nonEmptyCycles;
      sendWord(32'hdead_0006, 1'b0);
      sendWord(32'hbeef_0000, 1'b0);
      sendWord(32'h1234_5678, 1'b0);
      @(negedge clk); #1;
      checks++; if (nonEmptyCycles !== e0) begin failures++; $display("[TB] FAIL bad_nowrite got=%0d exp=%0d", nonEmptyCycles, e0); end
      checks++; if (debug[13:12] !== 2'd0) begin failures++; $display("[TB] FAIL bad_ingress got=%0d exp=0", debug[13:12]); end
      sendPacket(3'b110, 32'd0, 2, 32'hE000_0000);
      waitRun();
      for (int i = 0; i < 2; i++) begin
         pulseStrobe();
         checks++;
         if (sample !== 32'hE000_0000 + 32'(i)) begin
            failures++; $display("[TB] FAIL bad_next_%0d got=%h exp=%h", i, sample, 32'hE000_0000 + 32'(i));
         end
      end
      checks++; if (pkt_count !== 16'd1) begin failures++; $display("[TB] FAIL bad_pkt got=%0d exp=1", pkt_count); end
   endtask

   task automatic test_reset_mid();
      sendPacket(3'b110, 32'd0, 12, 32'hF000_0000);
      waitRun();
      pulseStrobe();
      pulseStrobe();
      checks++; if (fifo_occupied !== 16'd10) begin failures++; $display("[TB] FAIL mid_occ got=%0d exp=10", fifo_occupied); end
      rst = 1'b0;
      #1;
      checks++; if ({run, underrun, late} !== 3'b000) begin failures++; $display("[TB] FAIL mid_flags got=%b exp=000", {run, underrun, late}); end
      checks++; if (sample !== 32'd0) begin failures++; $display("[TB] FAIL mid_sample got=%h exp=0", sample); end
      checks++; if ({fifo_empty, fifo_occupied} !== {1'b1, 16'd0}) begin failures++; $display("[TB] FAIL mid_fifo got=%b/%0d exp=1/0", fifo_empty, fifo_occupied); end
      checks++; if (debug !== 32'h0000_0080) begin failures++; $display("[TB] FAIL mid_debug got=%h exp=00000080", debug); end
      @(negedge clk); #1;
      rst = 1'b1;
      rd_ready_i = 1'b1;
      #1;
      checks++; if (rd_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_disabled got=%b exp=0", rd_ready_o); end
      rd_ready_i = 1'b0;
   endtask

   initial begin
      $display("[TB] tx_control2 directed bench starting");
      test_reset();
      test_imm();
      test_late();
`ifdef TX_CONTROL2_TIMED_EN
      test_timed();
`endif
      test_underrun();
      test_bad_word1();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
